fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Drives the start/valid/busy handshake of the per-bin FFT wrappers from the initiator side.
//  - Collects a frame of N_POINTS complex samples from a serial valid/ready stream.
//  - Presents the frame as stable parallel X_real/X_imag buses and holds fft_start high.
//  - Waits until every bin wrapper reports valid, then captures their outputs.
//  - Sends the NUM_BINS results out on a serial valid/ready stream.
// PARAMETERS
//  N_POINTS  32  samples per frame; sets the X bus width
//  DATA_W    32  bits per real or imag word
//  NUM_BINS  1   number of bin wrappers sharing fft_start; results are flattened
//  TIMEOUT   64  RUN cycles allowed before the frame is aborted; must exceed wrapper latency (35)
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-high
//  in_valid     in   1                  input sample valid
//  in_ready     out  1                  sequencer can accept a sample
//  in_real      in   DATA_W             sample real part
//  in_imag      in   DATA_W             sample imag part
//  X_real       out  N_POINTS*DATA_W    slot k is bits [k*DATA_W +: DATA_W]
//  X_imag       out  N_POINTS*DATA_W    same layout as X_real
//  fft_start    out  1                  start level to all bin wrappers
//  fft_valid    in   NUM_BINS           per-wrapper valid
//  res_real     in   NUM_BINS*DATA_W    per-wrapper temp_real output, bin b at [b*DATA_W +: DATA_W]
//  res_imag     in   NUM_BINS*DATA_W    per-wrapper temp_imag output, same layout
//  out_valid    out  1                  result word valid
//  out_ready    in   1                  downstream accepts the result word
//  out_real     out  DATA_W             result real part
//  out_imag     out  DATA_W             result imag part
//  seq_busy     out  1                  high in RUN or DRAIN
//  err_timeout  out  1                  sticky abort flag
//  frames_done  out  16                 completed-frame count, wraps at 0xFFFF
// BEHAVIOUR
//  Reset (async)
//   - state=LOAD; sample and bin indices =0; X buses, result registers and all counters =0.
//   - fft_start=0, out_valid=0, err_timeout=0, seq_busy=0; in_ready=1 once reset deasserts.
//   - Reset in any state aborts the frame immediately; no partial output is emitted.
//  LOAD
//   - in_ready=1.
//   - On in_valid&&in_ready: write the sample to slot idx, then idx++.
//   - Acceptance of slot N_POINTS-1 -> RUN on the next cycle; idx=0.
//  RUN
//   - in_ready=0; fft_start=1, registered, high from the first RUN cycle.
//   - X buses stay frozen for the whole of RUN and DRAIN.
//   - tcnt counts RUN cycles.
//   - First edge with &fft_valid==1: capture res_real/res_imag into result regs, go to DRAIN, fft_start=0 next cycle.
//   - If tcnt reaches TIMEOUT-1 with &fft_valid==0: set err_timeout, fft_start=0, go to LOAD, discard the frame.
//   - fft_start therefore drops for at least 1 cycle between frames, which clears the wrapper counters.
//  DRAIN
//   - out_valid=1; out_real/out_imag = result[bin].
//   - Outputs stay stable while out_ready=0.
//   - On out_valid&&out_ready: bin++.
//   - Acceptance of bin NUM_BINS-1 -> LOAD, frames_done++, out_valid=0 the next cycle.
//  General rules
//   - No arithmetic on data; words pass through bit-exact.
//   - fft_valid is ignored outside RUN.
//   - in_valid is ignored unless in_ready=1.
//   - A sample accepted on the same edge that leaves LOAD cannot happen, because in_ready=0 in RUN.
// CONFIGURATION
//  FFT_SEQ_LAST_EN
//   - Defined: adds output out_last (1 bit) = out_valid && bin==NUM_BINS-1; reset value 0.
//   - Undefined: the port is absent and all other behaviour is identical.
// TESTING
//  1. Reset mid-RUN -> fft_start=0, in_ready=1, frame lost, out_valid never asserts.
//  2. Stream samples k=0..31 with real=k, imag=~k; wrapper model raises valid 35 cycles after start.
//     -> X slot 5 = 5 / 0xFFFFFFFA; fft_start high exactly 36 cycles; out_real/out_imag = model result; frames_done=1.
//  3. Gaps: in_valid toggles every other cycle -> still exactly 32 samples loaded; RUN is entered only after the 32nd.
//  4. Backpressure: out_ready=0 for 10 cycles in DRAIN with NUM_BINS=2 -> out_real held; bins emitted in order 0, 1.
//  5. fft_valid never rises -> err_timeout=1 after 64 RUN cycles; state returns to LOAD; the next good frame completes with err_timeout still 1.
//  6. Back-to-back frames -> fft_start low for at least 1 cycle between them; frames_done counts 1, 2, 3.
//     With FFT_SEQ_LAST_EN defined, out_last pulses once per frame.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the per-bin FFT wrappers: load N_POINTS samples, hold fft_start until all bins are valid, stream results.
// Define FFT_SEQ_LAST_EN to add the o_out_last marker on the final result word of each frame.
module fft_frame_sequencer #(
   parameter int N_POINTS = 32,
   parameter int DATA_W   = 32,
   parameter int NUM_BINS = 1,
   parameter int TIMEOUT  = 64
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [DATA_W-1:0]          i_in_real,
   input  logic [DATA_W-1:0]          i_in_imag,
   output logic [N_POINTS*DATA_W-1:0] o_x_real,
   output logic [N_POINTS*DATA_W-1:0] o_x_imag,
   output logic                       o_fft_start,
   input  logic [NUM_BINS-1:0]        i_fft_valid,
   input  logic [NUM_BINS*DATA_W-1:0] i_res_real,
   input  logic [NUM_BINS*DATA_W-1:0] i_res_imag,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [DATA_W-1:0]          o_out_real,
   output logic [DATA_W-1:0]          o_out_imag,
   output logic                       o_seq_busy,
   output logic                       o_err_timeout,
`ifdef FFT_SEQ_LAST_EN
   output logic                       o_out_last,
`endif
   output logic [15:0]                o_frames_done
);
   localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
   localparam int BW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);
   localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);
   localparam logic [TW-1:0] LAST_T   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [IW-1:0]              r_idx;
   logic [BW-1:0]              r_bin;
   logic [TW-1:0]              r_tcnt;
   logic [N_POINTS*DATA_W-1:0] r_x_real;
   logic [N_POINTS*DATA_W-1:0] r_x_imag;
   logic [NUM_BINS*DATA_W-1:0] r_res_real;
   logic [NUM_BINS*DATA_W-1:0] r_res_imag;
   logic                       r_fft_start;
   logic                       r_err_timeout;
   logic [15:0]                r_frames_done;
   logic                       w_all_valid;
   logic                       w_in_fire;
   logic                       w_out_fire;
   logic                       w_last_sample;
   logic                       w_last_bin;
   logic                       w_timeout;

   assign w_all_valid   = &i_fft_valid;
   assign w_in_fire     = (r_state == S_LOAD) && i_in_valid;
   assign w_out_fire    = (r_state == S_DRAIN) && i_out_ready;
   assign w_last_sample = (r_idx == LAST_IDX);
   assign w_last_bin    = (r_bin == LAST_BIN);
   // A valid seen on the last allowed RUN cycle still wins over the abort.
   assign w_timeout     = (r_state == S_RUN) && !w_all_valid && (r_tcnt == LAST_T);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_seq_busy  = 1'b0;
      case (r_state)
         S_LOAD: begin
            o_in_ready = 1'b1;
            if (w_in_fire && w_last_sample) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            o_seq_busy = 1'b1;
            if (w_all_valid)    w_state_nxt = S_DRAIN;
            else if (w_timeout) w_state_nxt = S_LOAD;
         end
         S_DRAIN: begin
            o_seq_busy  = 1'b1;
            o_out_valid = 1'b1;
            if (w_out_fire && w_last_bin) w_state_nxt = S_LOAD;
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_idx         <= '0;
         r_bin         <= '0;
         r_tcnt        <= '0;
         r_x_real      <= '0;
         r_x_imag      <= '0;
         r_res_real    <= '0;
         r_res_imag    <= '0;
         r_fft_start   <= 1'b0;
         r_err_timeout <= 1'b0;
         r_frames_done <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_in_fire) begin
                  r_x_real[r_idx*DATA_W +: DATA_W] <= i_in_real;
                  r_x_imag[r_idx*DATA_W +: DATA_W] <= i_in_imag;
                  r_idx <= w_last_sample ? '0 : r_idx + 1'b1;
                  if (w_last_sample) begin
                     r_fft_start <= 1'b1;
                     r_tcnt      <= '0;
                  end
               end
            end
            S_RUN: begin
               if (w_all_valid) begin
                  r_res_real  <= i_res_real;
                  r_res_imag  <= i_res_imag;
                  r_fft_start <= 1'b0;
                  r_bin       <= '0;
               end else if (w_timeout) begin
                  r_err_timeout <= 1'b1;
                  r_fft_start   <= 1'b0;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (w_out_fire) begin
                  if (w_last_bin) begin
                     r_bin         <= '0;
                     r_frames_done <= r_frames_done + 16'd1;
                  end else begin
                     r_bin <= r_bin + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_x_real      = r_x_real;
   assign o_x_imag      = r_x_imag;
   assign o_fft_start   = r_fft_start;
   assign o_out_real    = r_res_real[r_bin*DATA_W +: DATA_W];
   assign o_out_imag    = r_res_imag[r_bin*DATA_W +: DATA_W];
   assign o_err_timeout = r_err_timeout;
   assign o_frames_done = r_frames_done;
`ifdef FFT_SEQ_LAST_EN
   assign o_out_last    = o_out_valid && w_last_bin;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: vector table of frame scenarios, hand-written reset cases, and random frames.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
   localparam int NP = 32;
   localparam int DW = 32;
   localparam int NB = 2;
   localparam int TO = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_real;
   logic [DW-1:0]     in_imag;
   logic [NP*DW-1:0]  x_real;
   logic [NP*DW-1:0]  x_imag;
   logic              fft_start;
   logic [NB-1:0]     fft_valid;
   logic [NB*DW-1:0]  res_real;
   logic [NB*DW-1:0]  res_imag;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_real;
   logic [DW-1:0]     out_imag;
   logic              seq_busy;
   logic              err_timeout;
   logic [15:0]       frames_done;
`ifdef FFT_SEQ_LAST_EN
   logic              out_last;
`endif

   always #5 clk = ~clk;

   fft_frame_sequencer #(.N_POINTS(NP), .DATA_W(DW), .NUM_BINS(NB), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_real(in_real), .i_in_imag(in_imag),
      .o_x_real(x_real), .o_x_imag(x_imag), .o_fft_start(fft_start),
      .i_fft_valid(fft_valid), .i_res_real(res_real), .i_res_imag(res_imag),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_real(out_real), .o_out_imag(out_imag),
      .o_seq_busy(seq_busy), .o_err_timeout(err_timeout),
`ifdef FFT_SEQ_LAST_EN
      .o_out_last(out_last),
`endif
      .o_frames_done(frames_done)
   );

   // Bin wrapper model: counts cycles while start is high, valid once the count reaches its latency.
   int lat [NB];
   int wcnt = 0;
   always @(posedge clk) begin
      if (!fft_start) wcnt <= 0;
      else            wcnt <= wcnt + 1;
   end
   always_comb begin
      for (int b = 0; b < NB; b++) fft_valid[b] = fft_start && (wcnt >= lat[b]);
   end

   int low_run = 0;
   int min_gap = 1 << 30;
   bit ever_high = 1'b0;
   bit prev_s = 1'b0;
   always @(negedge clk) begin
      if (fft_start && !prev_s && ever_high && low_run < min_gap) min_gap = low_run;
      if (fft_start) begin
         ever_high = 1'b1;
         low_run   = 0;
      end else begin
         low_run++;
      end
      prev_s = fft_start;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int exp_frames = 0;
   bit exp_err = 1'b0;
   logic [DW-1:0]    sr [NP];
   logic [DW-1:0]    si [NP];
   logic [NP*DW-1:0] exp_xr;
   logic [NP*DW-1:0] exp_xi;

   typedef struct {
      int l0; int l1; int gap; int stall; bit ramp;
      int exp_sc; bit exp_to;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_sc(input int l0, input int l1);
      int m;
      m = (l0 > l1) ? l0 : l1;
      return (m <= TO - 1) ? m + 1 : TO;
   endfunction

   task automatic load_frame(input int gap, input bit ramp);
      int acc;
      int guard;
      int bad;
      bit fire;
      for (int k = 0; k < NP; k++) begin
         sr[k] = ramp ? DW'(k) : DW'($urandom());
         si[k] = ramp ? ~DW'(k) : DW'($urandom());
         exp_xr[k*DW +: DW] = sr[k];
         exp_xi[k*DW +: DW] = si[k];
      end
      acc = 0; guard = 0; bad = 0;
      while (acc < NP && guard < 2000) begin
         case (gap)
            0:       in_valid = 1'b1;
            1:       in_valid = (guard % 2 == 0);
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         in_real = in_valid ? sr[acc] : DW'($urandom());
         in_imag = in_valid ? si[acc] : DW'($urandom());
         if (!in_ready || fft_start || seq_busy) bad++;
         fire = in_valid && in_ready;
         tick();
         if (fire) acc++;
         guard++;
      end
      // junk offered while not ready must be ignored
      in_valid = 1'b1;
      in_real  = DW'($urandom());
      in_imag  = DW'($urandom());
      chk("load_count", acc, NP);
      chk("load_handshake", bad, 0);
      chk("run_entry", {fft_start, in_ready, seq_busy}, 3'b101);
      chk("x_loaded", (x_real === exp_xr) && (x_imag === exp_xi), 1);
   endtask

   task automatic run_frame(input int l0, input int l1, input int gap, input int stall,
                            input bit ramp, input int exp_sc, input bit exp_to);
      int sc;
      int xbad;
      int dbad;
      logic [DW-1:0] rr [NB];
      logic [DW-1:0] ri [NB];
      for (int b = 0; b < NB; b++) begin
         rr[b] = DW'($urandom());
         ri[b] = DW'($urandom());
         res_real[b*DW +: DW] = rr[b];
         res_imag[b*DW +: DW] = ri[b];
      end
      lat[0] = l0;
      lat[1] = l1;
      out_ready = 1'b0;
      load_frame(gap, ramp);
      if (ramp) begin
         chk("x5_real", x_real[5*DW +: DW], 5);
         chk("x5_imag", x_imag[5*DW +: DW], 32'hFFFF_FFFA);
      end
      sc = 0; xbad = 0;
      while (fft_start && sc < 200) begin
         if (x_real !== exp_xr || x_imag !== exp_xi || in_ready || out_valid) xbad++;
         tick();
         sc++;
      end
      for (int b = 0; b < NB; b++) begin
         res_real[b*DW +: DW] = DW'($urandom());
         res_imag[b*DW +: DW] = DW'($urandom());
      end
      chk("start_cycles", sc, exp_sc);
      if (exp_to) begin
         in_valid = 1'b0;
         exp_err  = 1'b1;
         chk("timeout_return", {err_timeout, seq_busy, in_ready, out_valid}, 4'b1010);
      end else begin
         dbad = 0;
         for (int b = 0; b < NB; b++) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
               if (!out_valid || out_real !== rr[b] || out_imag !== ri[b] || x_real !== exp_xr) dbad++;
`ifdef FFT_SEQ_LAST_EN
               if (out_last !== (b == NB - 1)) dbad++;
`endif
               tick();
            end
            out_ready = 1'b1;
            chk($sformatf("bin%0d_valid", b), out_valid, 1);
            chk($sformatf("bin%0d_real", b), out_real, rr[b]);
            chk($sformatf("bin%0d_imag", b), out_imag, ri[b]);
`ifdef FFT_SEQ_LAST_EN
            chk($sformatf("bin%0d_last", b), out_last, (b == NB - 1));
`endif
            tick();
         end
         in_valid  = 1'b0;
         out_ready = 1'b0;
         exp_frames++;
         chk("drain_hold", dbad, 0);
         chk("drain_exit", {out_valid, seq_busy, in_ready}, 3'b001);
         chk("frames_done", frames_done, exp_frames);
      end
      chk("err_timeout", err_timeout, exp_err);
      chk("x_frozen", xbad, 0);
   endtask

   initial begin
      vec_t tbl [7];
      int ov;
      int l0;
      int l1;
      tbl = '{
         '{35, 35, 0,  0, 1'b1, 36, 1'b0},
         '{35, 35, 1,  0, 1'b0, 36, 1'b0},
         '{20, 35, 0, 10, 1'b0, 36, 1'b0},
         '{80, 80, 0,  0, 1'b0, 64, 1'b1},
         '{35, 10, 2,  3, 1'b0, 36, 1'b0},
         '{63,  1, 0,  0, 1'b0, 64, 1'b0},
         '{64,  2, 0,  0, 1'b0, 64, 1'b1}
      };
      rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
      out_ready = 1'b0; res_real = '0; res_imag = '0;
      lat[0] = 35; lat[1] = 35;
      repeat (3) tick();
      chk("reset_ctrl", {fft_start, out_valid, seq_busy, err_timeout}, 4'b0000);
      chk("reset_frames", frames_done, 0);
      chk("reset_x", (x_real === '0) && (x_imag === '0), 1);
      rst = 1'b0;
      tick();
      chk("ready_after_reset", in_ready, 1);

      // reset in the middle of RUN loses the frame
      lat[0] = 1000; lat[1] = 1000;
      load_frame(0, 1'b0);
      repeat (10) tick();
      chk("midrun_start", fft_start, 1);
      rst = 1'b1;
      #1;
      chk("reset_async", {fft_start, seq_busy, out_valid}, 3'b000);
      chk("reset_async_x", (x_real === '0) && (x_imag === '0), 1);
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst = 1'b0;
      #1;
      chk("midrun_ready", in_ready, 1);
      ov = 0;
      repeat (80) begin
         tick();
         if (out_valid || fft_start) ov++;
      end
      chk("no_output_after_reset", ov, 0);
      chk("midrun_frames", frames_done, 0);
      chk("midrun_err", err_timeout, 0);
      exp_frames = 0; exp_err = 1'b0;
      out_ready = 1'b0;

      foreach (tbl[i])
         run_frame(tbl[i].l0, tbl[i].l1, tbl[i].gap, tbl[i].stall, tbl[i].ramp,
                   tbl[i].exp_sc, tbl[i].exp_to);

      for (int i = 0; i < 8; i++) begin
         l0 = $urandom_range(1, 72);
         l1 = $urandom_range(1, 72);
         run_frame(l0, l1, 2, $urandom_range(0, 4), 1'b0, model_sc(l0, l1),
                   ((l0 > l1) ? l0 : l1) > TO - 1);
      end

      chk("start_low_gap", min_gap >= 1, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
